// File: rtl/tart_spi_master_if.sv
// Command/response bus between a register client and the TART SPI master.
// The client side drives commands; the master side accepts them and
// returns the received data with a one-cycle rsp_valid pulse.
interface tart_spi_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [6:0]  cmd_addr;
    logic [1:0]  cmd_nbytes;
    logic [23:0] cmd_wdata;
    logic        rsp_valid;
    logic [23:0] rsp_data;
    logic        busy;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_nbytes, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_nbytes, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/tart_spi_master.sv
// SPI mode-0 register-access master for the TART radio front end.
// One transaction = address byte {write, addr[6:0]} followed by 0..3 data
// bytes, each byte separated by one idle SCK period. Data returned by the
// slave during the data bytes is collected right-justified in rsp_data.
// All SPI pins are registered so SCK/SSEL/MOSI are glitch free.
module tart_spi_master #(
    parameter int CLK_DIV    = 2,  // fpga_clk cycles per SCK half period (>= 1)
    parameter int SSEL_SETUP = 6,  // SSEL low to first SCK low phase (>= 1)
    parameter int SSEL_HOLD  = 6,  // last SCK fall to SSEL high (>= 1)
    parameter int SSEL_IDLE  = 6   // minimum SSEL high time between transfers (>= 1)
) (
    input  logic              fpga_clk,
    input  logic              rst,
    tart_spi_master_if.slave  cmd,
    output logic              spi_sck,
    output logic              spi_mosi,
    output logic              spi_ssel,
    input  logic              spi_miso
);

    localparam int BIT_LEN = 2 * CLK_DIV;
    localparam int MAX_A   = (BIT_LEN > SSEL_SETUP) ? BIT_LEN : SSEL_SETUP;
    localparam int MAX_B   = (SSEL_HOLD > SSEL_IDLE) ? SSEL_HOLD : SSEL_IDLE;
    localparam int MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW      = $clog2(MAX_CNT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_GAP,
        S_HOLD,
        S_WAIT_IDLE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;        // cycles within the current phase/bit
    logic [2:0]      bit_q, bit_d;        // bit index within the byte, 0 = MSB
    logic [1:0]      byte_q, byte_d;      // 0 = address byte, 1..nbytes = data
    logic            write_q, write_d;
    logic [6:0]      addr_q, addr_d;
    logic [1:0]      nbytes_q, nbytes_d;
    logic [23:0]     wdata_q, wdata_d;
    logic [23:0]     rx_q, rx_d;
    logic            sck_q, sck_d;
    logic            mosi_q, mosi_d;
    logic            ssel_q, ssel_d;
    logic            rsp_valid_q, rsp_valid_d;

    logic            cmd_ready_w;
    logic            accept_w;
    logic            bit_end;
    logic [23:0]     tx_shift;
    logic [7:0]      tx_byte;

    // Ready is forced low while reset is held so a command in that window is dropped.
    assign cmd_ready_w   = (state_q == S_IDLE) && !rst;
    assign accept_w      = cmd.cmd_valid && cmd_ready_w;

    assign cmd.cmd_ready = cmd_ready_w;
    assign cmd.busy      = (state_q != S_IDLE);
    assign cmd.rsp_valid = rsp_valid_q;
    assign cmd.rsp_data  = rx_q;

    assign spi_sck  = sck_q;
    assign spi_mosi = mosi_q;
    assign spi_ssel = ssel_q;

    // Next-state logic plus next values of the registered SPI pins.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        byte_d      = byte_q;
        write_d     = write_q;
        addr_d      = addr_q;
        nbytes_d    = nbytes_q;
        wdata_d     = wdata_q;
        rx_d        = rx_q;
        bit_end     = (cnt_q == CW'(BIT_LEN - 1));
        tx_shift    = '0;
        tx_byte     = '0;
        sck_d       = 1'b0;
        mosi_d      = 1'b0;
        ssel_d      = 1'b1;
        rsp_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept_w) begin
                    write_d  = cmd.cmd_write;
                    addr_d   = cmd.cmd_addr;
                    nbytes_d = cmd.cmd_nbytes;
                    wdata_d  = cmd.cmd_wdata;
                    rx_d     = '0;
                    cnt_d    = '0;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == CW'(SSEL_SETUP - 1)) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    byte_d  = '0;
                    state_d = S_SHIFT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SHIFT: begin
                if (bit_end) begin
                    cnt_d = '0;
                    // The address byte echo is meaningless, only data bytes are kept.
                    if (byte_q != 2'd0) begin
                        rx_d = {rx_q[22:0], spi_miso};
                    end
                    if (bit_q == 3'd7) begin
                        bit_d = '0;
                        if (byte_q == nbytes_q) begin
                            state_d = S_HOLD;
                        end else begin
                            byte_d  = byte_q + 2'd1;
                            state_d = S_GAP;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_GAP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_HOLD: begin
                if (cnt_q == CW'(SSEL_HOLD - 1)) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT_IDLE: begin
                if (cnt_q == CW'(SSEL_IDLE - 1)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Write data is left-justified: data byte 1 is wdata[23:16].
        tx_shift    = wdata_d << {byte_d - 2'd1, 3'b000};
        tx_byte     = (byte_d == 2'd0) ? {write_d, addr_d}
                                       : (write_d ? tx_shift[23:16] : 8'h00);
        sck_d       = (state_d == S_SHIFT) && (cnt_d >= CW'(CLK_DIV));
        mosi_d      = (state_d == S_SHIFT) ? tx_byte[3'd7 - bit_d] : 1'b0;
        ssel_d      = (state_d == S_IDLE) || (state_d == S_WAIT_IDLE);
        rsp_valid_d = (state_q == S_HOLD) && (state_d == S_WAIT_IDLE);
    end

    // State, counters, latched command and registered SPI pins.
    always_ff @(posedge fpga_clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            byte_q      <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            nbytes_q    <= '0;
            wdata_q     <= '0;
            rx_q        <= '0;
            sck_q       <= 1'b0;
            mosi_q      <= 1'b0;
            ssel_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            byte_q      <= byte_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            nbytes_q    <= nbytes_d;
            wdata_q     <= wdata_d;
            rx_q        <= rx_d;
            sck_q       <= sck_d;
            mosi_q      <= mosi_d;
            ssel_q      <= ssel_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

endmodule

// File: tb/tb_tart_spi_master.sv
// Bench for tart_spi_master: a behavioural mode-0 SPI slave feeds MISO and
// records MOSI bytes; each transaction is compared against expectations
// built from the byte-level protocol description.
module tb_tart_spi_master;

    localparam int CLK_DIV = 2;
    localparam int SETUP   = 6;
    localparam int HOLD    = 6;
    localparam int IDLE    = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic sck, mosi, ssel;
    logic miso = 1'b0;
    logic sck1, mosi1, ssel1;
    logic miso1;

    tart_spi_master_if bus();
    tart_spi_master_if bus1();

    tart_spi_master #(.CLK_DIV(CLK_DIV), .SSEL_SETUP(SETUP), .SSEL_HOLD(HOLD), .SSEL_IDLE(IDLE)) dut (
        .fpga_clk (clk),
        .rst      (rst),
        .cmd      (bus),
        .spi_sck  (sck),
        .spi_mosi (mosi),
        .spi_ssel (ssel),
        .spi_miso (miso)
    );

    tart_spi_master #(.CLK_DIV(1), .SSEL_SETUP(6), .SSEL_HOLD(6), .SSEL_IDLE(6)) dut1 (
        .fpga_clk (clk),
        .rst      (rst),
        .cmd      (bus1),
        .spi_sck  (sck1),
        .spi_mosi (mosi1),
        .spi_ssel (ssel1),
        .spi_miso (miso1)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task tick;
        @(negedge clk);
        #1;
    endtask

    // ---------------- slave model / monitor for dut ----------------
    logic [31:0] slave_word = '0;   // MISO stream, bit 31 first
    int          slave_idx  = 0;
    logic [7:0]  cap_byte   = '0;
    int          cap_bits   = 0;
    logic [7:0]  mosi_bytes[$];
    int          low_cnt = 0, last_low = 0, high_cnt = 0, last_high = 0;
    int          rise_cnt = 0, sck_high_cnt = 0, rv_cnt = 0;
    logic        prev_sck = 1'b0, prev_ssel = 1'b1;

    initial begin
        forever begin
            @(negedge clk);
            if (prev_ssel === 1'b1 && ssel === 1'b0) begin
                last_high = high_cnt;
                low_cnt = 0; rise_cnt = 0; sck_high_cnt = 0; cap_bits = 0;
                mosi_bytes.delete();
                slave_idx = 0;
                miso = slave_word[31];
            end
            if (prev_ssel === 1'b0 && ssel === 1'b1) begin
                last_low = low_cnt;
                high_cnt = 0;
            end
            if (ssel === 1'b1) high_cnt++;
            else if (ssel === 1'b0) low_cnt++;
            if (sck === 1'b1) sck_high_cnt++;
            if (prev_sck === 1'b0 && sck === 1'b1) begin
                rise_cnt++;
                cap_byte = {cap_byte[6:0], mosi};
                cap_bits++;
                if (cap_bits % 8 == 0) mosi_bytes.push_back(cap_byte);
            end
            if (prev_sck === 1'b1 && sck === 1'b0) begin
                slave_idx++;
                miso = (slave_idx < 32) ? slave_word[31 - slave_idx] : 1'b0;
            end
            if (bus.rsp_valid === 1'b1) rv_cnt++;
            prev_sck  = sck;
            prev_ssel = ssel;
        end
    end

    // ---------------- monitor for dut1 (CLK_DIV = 1) ----------------
    int   low1 = 0, last_low1 = 0, rise1 = 0, shigh1 = 0, rv1 = 0;
    logic prev_sck1 = 1'b0, prev_ssel1 = 1'b1;

    initial begin
        forever begin
            @(negedge clk);
            if (prev_ssel1 === 1'b1 && ssel1 === 1'b0) begin
                low1 = 0; rise1 = 0; shigh1 = 0;
            end
            if (prev_ssel1 === 1'b0 && ssel1 === 1'b1) last_low1 = low1;
            if (ssel1 === 1'b0) low1++;
            if (sck1 === 1'b1) shigh1++;
            if (prev_sck1 === 1'b0 && sck1 === 1'b1) rise1++;
            if (bus1.rsp_valid === 1'b1) rv1++;
            prev_sck1  = sck1;
            prev_ssel1 = ssel1;
        end
    end

    // Prepare the slave's MISO stream: junk during the address byte, then data.
    task automatic load_slave(input logic [1:0] n, input logic [23:0] rd, input logic [7:0] junk);
        logic [23:0] data;
        data = (n == 2'd0) ? 24'h0 : (rd & (24'hFFFFFF >> (24 - 8 * int'(n))));
        slave_word = {junk, 24'(data << (24 - 8 * int'(n)))};
    endtask

    task automatic drive_cmd(input logic w, input logic [6:0] a, input logic [1:0] n, input logic [23:0] wd);
        bus.cmd_write  = w;
        bus.cmd_addr   = a;
        bus.cmd_nbytes = n;
        bus.cmd_wdata  = wd;
    endtask

    task automatic run_txn(input logic w, input logic [6:0] a, input logic [1:0] n,
                           input logic [23:0] wd, input logic [23:0] rd, input logic [7:0] junk);
        logic [23:0] exp_rsp;
        logic [7:0]  exp_b[$];
        int          base, cyc, exp_low;
        exp_rsp = (n == 2'd0) ? 24'h0 : (rd & (24'hFFFFFF >> (24 - 8 * int'(n))));
        exp_b.push_back({w, a});
        for (int k = 0; k < int'(n); k++) exp_b.push_back(w ? wd[23 - 8 * k -: 8] : 8'h00);
        exp_low = SETUP + (int'(n) + 1) * 16 * CLK_DIV + int'(n) * 2 * CLK_DIV + HOLD;
        load_slave(n, rd, junk);
        base = rv_cnt;

        cyc = 0;
        while (bus.cmd_ready !== 1'b1 && cyc < 100) begin tick; cyc++; end
        check_eq("ready_before", bus.cmd_ready, 1);
        drive_cmd(w, a, n, wd);
        bus.cmd_valid = 1'b1;
        tick;
        bus.cmd_valid = 1'b0;
        check_eq("ready_after_accept", bus.cmd_ready, 0);
        check_eq("busy_after_accept", bus.busy, 1);
        check_eq("ssel_after_accept", ssel, 0);

        cyc = 0;
        while (rv_cnt == base && cyc < 2000) begin tick; cyc++; end
        check_eq("rsp_seen", rv_cnt - base, 1);
        check_eq("ssel_at_rsp", ssel, 1);
        check_eq("busy_at_rsp", bus.busy, 1);
        check_eq("rsp_data", bus.rsp_data, exp_rsp);
        check_eq("ssel_low_cycles", last_low, exp_low);
        check_eq("sck_rises", rise_cnt, 8 * (int'(n) + 1));
        check_eq("sck_high_cycles", sck_high_cnt, 8 * (int'(n) + 1) * CLK_DIV);
        check_eq("mosi_nbytes", mosi_bytes.size(), exp_b.size());
        for (int i = 0; i < exp_b.size(); i++)
            check_eq($sformatf("mosi_byte%0d", i),
                     (i < mosi_bytes.size()) ? {24'h0, mosi_bytes[i]} : 32'hFFFF_FFFF, exp_b[i]);

        cyc = 0;
        while (bus.cmd_ready !== 1'b1 && cyc < 100) begin tick; cyc++; end
        check_eq("idle_cycles", cyc, IDLE);
        check_eq("rsp_pulses", rv_cnt - base, 1);
        check_eq("rsp_data_stable", bus.rsp_data, exp_rsp);
        $display("txn w=%0d addr=0x%02h n=%0d wdata=0x%06h rsp=0x%06h exp=0x%06h ssel_low=%0d",
                 w, a, n, wd, bus.rsp_data, exp_rsp, last_low);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, cyc;
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        drive_cmd(1'b0, 7'h0, 2'd0, 24'h0);
        bus1.cmd_valid = 1'b0; bus1.cmd_write = 1'b0; bus1.cmd_addr = 7'h0;
        bus1.cmd_nbytes = 2'd0; bus1.cmd_wdata = 24'h0;
        miso1 = 1'b1;
        repeat (3) tick;

        // reset state
        check_eq("rst_ready", bus.cmd_ready, 0);
        check_eq("rst_ssel", ssel, 1);
        check_eq("rst_sck", sck, 0);
        check_eq("rst_mosi", mosi, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_rsp_valid", bus.rsp_valid, 0);
        check_eq("rst_rsp_data", bus.rsp_data, 0);
        rst = 1'b0;
        tick;
        check_eq("ready_after_rst", bus.cmd_ready, 1);

        // directed transactions
        run_txn(1'b0, 7'h00, 2'd1, 24'h000000, 24'h0000F0, 8'h5C);
        run_txn(1'b1, 7'h01, 2'd1, 24'h010000, 24'h000033, 8'hA7);
        run_txn(1'b0, 7'h04, 2'd3, 24'h000000, 24'hA53C0F, 8'hFF);
        run_txn(1'b1, 7'h7F, 2'd0, 24'hFFFFFF, 24'hFFFFFF, 8'hFF);

        // reset during bit 3 of byte 1
        load_slave(2'd2, 24'h00BEEF, 8'h11);
        drive_cmd(1'b0, 7'h22, 2'd2, 24'h0);
        base = rv_cnt;
        bus.cmd_valid = 1'b1;
        tick;
        bus.cmd_valid = 1'b0;
        cyc = 0;
        while (rise_cnt < 12 && cyc < 500) begin tick; cyc++; end
        check_eq("reached_byte1_bit3", rise_cnt, 12);
        rst = 1'b1;
        bus.cmd_valid = 1'b1;
        tick;
        check_eq("abort_ssel", ssel, 1);
        check_eq("abort_sck", sck, 0);
        check_eq("abort_mosi", mosi, 0);
        check_eq("abort_busy", bus.busy, 0);
        check_eq("abort_rsp_data", bus.rsp_data, 0);
        check_eq("abort_ready_in_rst", bus.cmd_ready, 0);
        rst = 1'b0;
        bus.cmd_valid = 1'b0;
        tick;
        check_eq("abort_ready_after", bus.cmd_ready, 1);
        check_eq("abort_cmd_dropped", bus.busy, 0);
        repeat (4) tick;
        check_eq("abort_no_rsp", rv_cnt - base, 0);
        run_txn(1'b1, 7'h22, 2'd2, 24'hC3A500, 24'h001234, 8'h80);

        // back-to-back with cmd_valid held high
        load_slave(2'd1, 24'h00005A, 8'h99);
        drive_cmd(1'b0, 7'h10, 2'd1, 24'h0);
        base = rv_cnt;
        bus.cmd_valid = 1'b1;
        cyc = 0;
        while (rv_cnt - base < 2 && cyc < 3000) begin tick; cyc++; end
        bus.cmd_valid = 1'b0;
        check_eq("b2b_rsp_count", rv_cnt - base, 2);
        check_eq("b2b_ssel_high_gap", last_high, IDLE + 1);
        check_eq("b2b_rsp_data", bus.rsp_data, 24'h00005A);
        cyc = 0;
        while (bus.cmd_ready !== 1'b1 && cyc < 100) begin tick; cyc++; end
        repeat (3) tick;
        check_eq("b2b_no_third", rv_cnt - base, 2);
        check_eq("b2b_idle", bus.busy, 0);

        // randomized transactions
        for (int t = 0; t < 16; t++) begin
            run_txn(1'($urandom), 7'($urandom), 2'($urandom_range(0, 3)),
                    24'($urandom), 24'($urandom), 8'($urandom));
        end

        // CLK_DIV = 1, no data bytes
        cyc = 0;
        while (bus1.cmd_ready !== 1'b1 && cyc < 100) begin tick; cyc++; end
        bus1.cmd_addr   = 7'h15;
        bus1.cmd_valid  = 1'b1;
        tick;
        bus1.cmd_valid  = 1'b0;
        cyc = 0;
        while (rv1 == 0 && cyc < 500) begin tick; cyc++; end
        check_eq("div1_rsp_count", rv1, 1);
        check_eq("div1_ssel_low", last_low1, 28);
        check_eq("div1_sck_rises", rise1, 8);
        check_eq("div1_sck_high_cycles", shigh1, 8);
        check_eq("div1_rsp_data", bus1.rsp_data, 0);
        $display("txn div1 addr=0x15 n=0 rsp=0x%06h ssel_low=%0d", bus1.rsp_data, last_low1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/tart_spi_master.md
TART_SPI_MASTER -- requirements
Module: tart_spi_master

Interface
REQ-001 Parameter CLK_DIV, default 2: fpga_clk cycles per SCK half-period (min 1); 2 gives 8 MHz SCK from 32 MHz.
REQ-002 Parameter SSEL_SETUP, default 6: fpga_clk cycles from SSEL falling to first SCK low phase.
REQ-003 Parameter SSEL_HOLD, default 6: fpga_clk cycles from last SCK falling to SSEL rising.
REQ-004 Parameter SSEL_IDLE, default 6: minimum fpga_clk cycles SSEL stays high between transactions.
REQ-005 fpga_clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 cmd_valid  in  1  command request.
REQ-008 cmd_ready  out  1  high when a command can be accepted.
REQ-009 cmd_write  in  1  1 = register write, 0 = register read; sent as bit 7 of address byte.
REQ-010 cmd_addr  in  7  register address; bits 6:0 of address byte.
REQ-011 cmd_nbytes  in  2  data bytes after address byte (0..3).
REQ-012 cmd_wdata  in  24  write data; MSB-first, byte k from bits [23-8k:16-8k].
REQ-013 spi_sck  out  1  SPI clock, mode 0 (idle low).
REQ-014 spi_mosi  out  1  master out.
REQ-015 spi_ssel  out  1  active-low slave select.
REQ-016 spi_miso  in  1  slave out.
REQ-017 rsp_valid  out  1  one-cycle pulse at transaction end.
REQ-018 rsp_data  out  24  bytes received during data phase, right-justified, first received byte most significant.
REQ-019 busy  out  1  high from acceptance until cmd_ready returns.

Function
REQ-020 Command accepted on the cycle cmd_valid & cmd_ready; all cmd_* fields latched then; cmd_ready low the next cycle.
REQ-021 cmd_valid while cmd_ready low is ignored; no queuing.
REQ-022 States: IDLE -> SETUP -> SHIFT -> (GAP -> SHIFT)* -> HOLD -> WAIT_IDLE -> IDLE.
REQ-023 IDLE: ssel=1, sck=0, mosi=0, cmd_ready=1 (unless in rst).
REQ-024 SETUP: ssel=0 from cycle after acceptance for SSEL_SETUP cycles, sck=0.
REQ-025 SHIFT: 8 bits per byte, MSB first; per bit, sck low CLK_DIV cycles then high CLK_DIV cycles; mosi updated on first cycle of low phase.
REQ-026 miso sampled into shift register on last fpga_clk cycle of each sck high phase.
REQ-027 Byte 0 = {cmd_write, cmd_addr}; bytes 1..cmd_nbytes from cmd_wdata for writes, 0x00 for reads.
REQ-028 GAP between consecutive bytes: sck=0, mosi=0, 2*CLK_DIV cycles (one SCK period).
REQ-029 Byte length 16*CLK_DIV cycles; SSEL low duration = SSEL_SETUP + (N+1)*16*CLK_DIV + N*2*CLK_DIV + SSEL_HOLD, N = cmd_nbytes.
REQ-030 HOLD: sck=0 for SSEL_HOLD cycles, then ssel=1 and rsp_valid=1 on the same cycle.
REQ-031 rsp_data: bits received during address byte discarded; data bytes right-justified, unused upper bits 0; valid and stable from rsp_valid until next acceptance.
REQ-032 rsp_data captured for writes too (slave echo); cmd_nbytes=0 gives rsp_data=0.
REQ-033 WAIT_IDLE: ssel high SSEL_IDLE cycles; cmd_ready rises on the following cycle.
REQ-034 Bit and byte counters sized for 32 bits max; no wrap beyond cmd_nbytes+1 bytes.

Reset
REQ-035 rst at any time, including mid-byte: next cycle ssel=1, sck=0, mosi=0, rsp_valid=0, rsp_data=0, busy=0, state IDLE; no partial rsp_valid.
REQ-036 cmd_ready=0 while rst high and 1 the cycle after rst deasserts; command presented during rst is dropped.

Verification
REQ-037 Defaults; read, addr 0x00, nbytes 1, slave drives 0xF0 -> mosi bytes 0x00,0x00; 16 sck rising edges; ssel low 80 cycles; rsp_data=0x0000F0, one rsp_valid pulse.
REQ-038 Write, addr 0x01, nbytes 1, wdata 0x010000 -> mosi bytes 0x81,0x01 MSB first, 4-cycle sck-low gap between bytes, busy high throughout.
REQ-039 Read, addr 0x04, nbytes 3, slave returns 0xA5,0x3C,0x0F -> ssel low 6+128+12+6=152 cycles; rsp_data=0xA53C0F.
REQ-040 rst asserted during bit 3 of byte 1 -> next cycle ssel=1, sck=0, no rsp_valid; new command accepted cycle after rst release completes normally.
REQ-041 Back-to-back cmd_valid held high -> second command accepted only after 6 ssel-high cycles; cmd_valid during busy ignored.
REQ-042 CLK_DIV=1, nbytes 0 -> 8 sck periods of 2 cycles, rsp_data=0, ssel low 6+16+6=28 cycles.
